// File: rtl/switch_pkg.sv
// Shared switch types: flit width, port count and idle word.
// Used by the crossbar, its ingress stage and the egress stage.
package switch_pkg;

   localparam int FLIT_W    = 15;
   localparam int NUM_PORTS = 4;

   typedef logic [FLIT_W-1:0] flit_t;

   localparam flit_t IDLE_FLIT = '0;

   function automatic logic is_idle(
      input flit_t f
   );
      return f == IDLE_FLIT;
   endfunction

endpackage

// File: rtl/switch_egress_fifo.sv
// One egress channel: FIFO storage, pointers, occupancy flags and
// optional saturating drop counter (SWITCH_EGRESS_DROP_CNT_EN).
module switch_egress_fifo
   import switch_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_ready,
   input  flit_t      in_flit,
   output logic       out_valid,
   output flit_t      out_data,
   input  logic       out_ready,
   output logic       almost_full,
`ifdef SWITCH_EGRESS_DROP_CNT_EN
   output logic       full,
   output logic [7:0] drop_cnt
`else
   output logic       full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   flit_t mem [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_nx;
   logic [AW-1:0] wr_ptr_nx;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nx;
   flit_t         head_nx;

   logic push;
   logic pop;
   logic is_full;
   logic wr_en;
   logic drop;

   assign push    = sw_ready && !is_idle(in_flit);
   assign pop     = out_valid && out_ready;
   assign is_full = (count == DEPTH_C);

   // A pop frees the slot the push would otherwise be refused for.
   assign wr_en = push && (!is_full || pop);
   assign drop  = push && is_full && !pop;

   always_comb begin
      count_nx  = count;
      rd_ptr_nx = rd_ptr;
      wr_ptr_nx = wr_ptr;
      if (wr_en && !pop) begin
         count_nx = count + ONE_C;
      end else if (pop && !wr_en) begin
         count_nx = count - ONE_C;
      end
      if (pop) begin
         rd_ptr_nx = rd_ptr + AW'(1);
      end
      if (wr_en) begin
         wr_ptr_nx = wr_ptr + AW'(1);
      end
   end

   // Head register: the incoming word becomes head when it is
   // the only entry after this edge; otherwise follow rd_ptr.
   always_comb begin
      head_nx = out_data;
      if (wr_en && count_nx == ONE_C) begin
         head_nx = in_flit;
      end else if (pop && count_nx != '0) begin
         head_nx = mem[rd_ptr_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_flit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         out_data    <= IDLE_FLIT;
         almost_full <= 1'b0;
         full        <= 1'b0;
      end else begin
         rd_ptr      <= rd_ptr_nx;
         wr_ptr      <= wr_ptr_nx;
         count       <= count_nx;
         out_valid   <= (count_nx != '0);
         out_data    <= head_nx;
         almost_full <= (count_nx >= AF_C);
         full        <= (count_nx == DEPTH_C);
      end
   end

`ifdef SWITCH_EGRESS_DROP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: rtl/switch_egress.sv
// Egress buffering behind the 4x4 crossbar: one FIFO per output port.
// Drop counters present only with SWITCH_EGRESS_DROP_CNT_EN.
module switch_egress
   import switch_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sw_ready,
   input  logic [14:0] oport0,
   input  logic [14:0] oport1,
   input  logic [14:0] oport2,
   input  logic [14:0] oport3,
   output logic [3:0]  out_valid,
   output logic [14:0] out_data0,
   output logic [14:0] out_data1,
   output logic [14:0] out_data2,
   output logic [14:0] out_data3,
   input  logic [3:0]  out_ready,
   output logic [3:0]  almost_full,
`ifdef SWITCH_EGRESS_DROP_CNT_EN
   output logic [3:0]  full,
   output logic [7:0]  drop_cnt0,
   output logic [7:0]  drop_cnt1,
   output logic [7:0]  drop_cnt2,
   output logic [7:0]  drop_cnt3
`else
   output logic [3:0]  full
`endif
);

   flit_t in_w  [NUM_PORTS];
   flit_t out_w [NUM_PORTS];

   assign in_w[0] = oport0;
   assign in_w[1] = oport1;
   assign in_w[2] = oport2;
   assign in_w[3] = oport3;

   assign out_data0 = out_w[0];
   assign out_data1 = out_w[1];
   assign out_data2 = out_w[2];
   assign out_data3 = out_w[3];

`ifdef SWITCH_EGRESS_DROP_CNT_EN
   logic [7:0] dc_w [NUM_PORTS];

   assign drop_cnt0 = dc_w[0];
   assign drop_cnt1 = dc_w[1];
   assign drop_cnt2 = dc_w[2];
   assign drop_cnt3 = dc_w[3];
`endif

   for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
      switch_egress_fifo #(
         .DEPTH     (DEPTH),
         .AF_MARGIN (AF_MARGIN)
      ) u_fifo (
         .clk         (clk),
         .rst         (rst),
         .sw_ready    (sw_ready),
         .in_flit     (in_w[n]),
         .out_valid   (out_valid[n]),
         .out_data    (out_w[n]),
         .out_ready   (out_ready[n]),
         .almost_full (almost_full[n]),
`ifdef SWITCH_EGRESS_DROP_CNT_EN
         .full        (full[n]),
         .drop_cnt    (dc_w[n])
`else
         .full        (full[n])
`endif
      );
   end

endmodule

// File: doc/switch_egress.md
# switch_egress

Output-side buffering stage sitting directly downstream of the 4x4 crossbar. Captures each non-idle 15-bit word the crossbar drives on oport0..oport3 during its output slots, queues it in a per-port FIFO and delivers it to the port consumer over a valid/ready handshake. The crossbar has no backpressure input, so the block reports per-port fill level to the upstream scheduler and drops, and optionally counts, words that arrive at a full queue.

## Interface
Parameters:
- DEPTH, 8: entries per port FIFO; power of two, minimum 4.
- AF_MARGIN, 2: almost_full asserts when occupancy is at least DEPTH-AF_MARGIN.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_ready  input  1  crossbar output-slot strobe; oport words are valid in cycles where this is high.
- oport0..oport3  input  15 each  crossbar output words; 15'd0 is the idle word.
- out_valid  output  4  bit n: port n FIFO head is valid.
- out_data0..out_data3  output  15 each  FIFO head word per port.
- out_ready  input  4  bit n: consumer n accepts the head this cycle.
- almost_full  output  4  bit n: port n occupancy ≥ DEPTH-AF_MARGIN.
- full  output  4  bit n: port n occupancy == DEPTH.
- drop_cnt0..drop_cnt3  output  8 each  saturating per-port drop counts; present only with SWITCH_EGRESS_DROP_CNT_EN.

## Operation
- Four independent, identical port channels. Channel n:
  - Push when sw_ready && oportn != 15'd0.
  - Pop when out_valid[n] && out_ready[n].
- Occupancy count: 0..DEPTH, log2(DEPTH)+1 bits. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push with count < DEPTH: write at wr_ptr, then wr_ptr+1.
- Push with count == DEPTH and no pop: word is discarded and the drop event fires.
- Push and pop in the same cycle when full: the push is accepted and the count stays at DEPTH. No drop.
- Push and pop in the same cycle when empty: only the push takes effect; there is no bypass path.
- out_data is the registered head word. It holds its value while out_valid=1 and out_ready=0. It is don't-care-stable (last value) when out_valid=0.
- Idle words (15'd0) are never stored, even while sw_ready=1.
- Reset mid-operation: all FIFO contents are lost immediately. Any words in flight from the crossbar are not recovered.

## Timing
- Reset values: out_valid=0, out_data*=0, almost_full=0, full=0, drop_cnt*=0, all pointers and counts 0.
- Push-to-visible latency is 1 cycle. A word pushed on edge k appears with out_valid=1 after edge k when the FIFO was empty.
- A pop on edge k presents the next entry after edge k (back-to-back drain at 1 word/cycle).
- almost_full and full are registered and reflect occupancy after the current edge.
- 4 consecutive sw_ready cycles (one crossbar burst) deliver up to 4 words per port.

## Configuration
- SWITCH_EGRESS_DROP_CNT_EN defined:
  - drop_cnt0..3 ports and counters exist.
  - Each counter increments by 1 per dropped word and saturates at 8'hFF.
  - Counters are cleared only by rst.
- Not defined:
  - drop_cnt ports and logic are absent.
  - Drops still occur silently.
  - All other behaviour is identical.

## Structure
- Shared package switch_pkg holds:
  - FLIT_W=15, NUM_PORTS=4, IDLE_FLIT=15'd0.
  - The flit typedef, reused by the crossbar and its ingress stage.
- One sub-module, switch_egress_fifo, implements a single channel: storage, pointers, count, flags and the optional drop counter. switch_egress instantiates it 4 times.

## Test plan
- Reset then idle: rst high 70 ns, then sw_ready=1 with all oport=0 for 4 cycles → out_valid=4'b0000, full=0, drop_cnt*=0.
- Single burst: sw_ready=1 for 4 cycles, oport0=15'h0011/0012/0013/0014, out_ready=4'b1111 → out_data0 emits 0011..0014 in order, 1 cycle after each push; other ports stay invalid.
- Fill and overflow (DEPTH=8), out_ready=0:
  - 10 words to port 2 → full[2]=1 after the 8th push.
  - almost_full[2]=1 after the 6th push.
  - drop_cnt2=2; the queue holds words 1..8.
- Simultaneous push/pop at full: port 1 full, one push plus out_ready[1]=1 in the same cycle → count stays 8, no drop, head advances by one, new word is at the tail.
- Wrap-around: 20 words streamed through port 3 with out_ready toggling 1,0,1,0 → all 20 delivered in order and uncorrupted across pointer wrap.
- Reset mid-burst: assert rst in the 3rd sw_ready cycle with ports half full → all outputs 0 immediately (async); after release, the first new push reappears normally.
